counter_sched: RTL and testbench
================================

# counter_sched

Round-robin scheduler that shares a single up/down FSM counter (act/up_dn command inputs, count/ovflw status outputs) between NREQ requesters. Each requester asks for a burst of `len` up- or down-steps. The scheduler grants one requester at a time and drives the counter's `act`/`up_dn` for exactly `len` steps. It reports completion per requester and latches a sticky fault if the counter overflows.

## Interface
- NREQ, 4: number of requesters (2..8).
- CW, 4: counter width; must equal the shared counter's width.
- LW, 4: burst-length field width; max burst 2^LW-1.

- clk  in  1  clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held until its `done`.
- req_up  in  NREQ  direction per requester: 1 = up, 0 = down.
- req_len  in  NREQ*LW  burst length; requester i in bits [i*LW +: LW].
- cnt_in  in  CW  counter `count` output.
- ovflw_in  in  1  counter `ovflw` output.
- act  out  1  counter act command.
- up_dn  out  1  counter direction command.
- gnt  out  NREQ  one-hot grant; high from grant through the DONE cycle.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  high with `done` when the burst was rejected (guard only).
- busy  out  1  high in any state except IDLE and FAULT.
- fault  out  1  sticky; counter overflow seen.

## Operation
- All outputs are registered. Reset value of every output is 0. Round-robin pointer resets to 0, so requester 0 has highest priority first.
- States:
  - IDLE: if any `req`, the winner is the first set bit searching from the pointer upward with wrap. At the clock edge:
    - set `gnt`;
    - latch `req_up` and `req_len` of the winner;
    - set pointer = winner+1 mod NREQ;
    - go to RUN, or go to DONE if the latched len = 0.
  - RUN: act=1, up_dn=latched direction. A down-counter of remaining length decrements each cycle. After exactly len RUN cycles, go to WAIT.
  - WAIT: one cycle, act=0. The counter performs its final step here.
  - DONE: one cycle. done[winner]=1, gnt still held, cnt_in is final. Then go to IDLE with gnt=0.
  - FAULT: gnt, act, done, busy = 0; fault=1. All requests are ignored. Exit only via reset_n.
- ovflw_in=1 sampled in RUN, WAIT or DONE causes FAULT at the next edge. No `done` is issued for the aborted burst.
- Deasserting `req` mid-burst is ignored; the burst completes. `req_up` and `req_len` changes after grant are ignored.
- Requests arriving during a burst are arbitrated only on return to IDLE.
- A requester may reassert `req` the cycle after its `done`. Round-robin still serves any other pending requester first.

## Timing
- Grant latency: `req` seen in IDLE at cycle t -> gnt and act both high at cycle t+1.
- Burst of len L ≥ 1: act high cycles t+1..t+L, WAIT at t+L+1, done at t+L+2, IDLE at t+L+3. The counter performs exactly L steps.
- len=0: DONE at t+1 with no act; IDLE at t+2.
- Back-to-back bursts have at least one IDLE cycle between them with act=0, so the counter returns to its idle state between grants.
- Reset mid-burst: all outputs go to 0 immediately. The counter shares reset_n and restarts from count 0.

## Configuration
- COUNTER_SCHED_GUARD_EN defined: the IDLE grant step checks headroom against cnt_in in CW+1-bit arithmetic.
  - Reject if up and cnt_in+len > 2^CW-1.
  - Reject if down and len > cnt_in.
  - On reject: go to DONE directly with err=1, no act pulse, counter untouched.
- Not defined: no check and `err` is tied to 0. Out-of-range bursts drive the counter into overflow, which leads to FAULT.

## Test plan
- cnt_in=0; req[0] up, len 5 at cycle t -> gnt[0] at t+1; act=1, up_dn=1 for t+1..t+5; done[0] at t+7; count=5; busy low at t+8.
- req[0] and req[2] asserted together, then req[0] and req[1] pending after req[2]'s done -> grant order 0, 2, 0. Grants never overlap, and there is at least one act=0 cycle between bursts.
- req[3] down, len 0 -> gnt[3] and done[3] both at t+1; act never high; count unchanged.
- Without guard: count=5, req[1] up, len 15 -> ovflw_in rises during the burst -> fault=1 and gnt=act=0 next cycle; no done[1]. A later req[0] is ignored until reset.
- With COUNTER_SCHED_GUARD_EN, same stimulus -> done[1] and err=1 at t+1; act stays 0; count stays 5; fault=0.
- reset_n low during RUN of a len-10 burst -> all outputs 0 asynchronously. After release, req[2] up, len 3 is granted first (pointer=0, no other requests) and finishes with count=3.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that lends one shared up/down counter to NREQ requesters.
// Define COUNTER_SCHED_GUARD_EN to reject, at grant time, bursts that would overflow the counter.
module counter_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 4,
    parameter int unsigned LW   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_up,
    input  logic [NREQ*LW-1:0]   req_len,
    input  logic [CW-1:0]        cnt_in,
    input  logic                 ovflw_in,
    output logic                 act,
    output logic                 up_dn,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 busy,
    output logic                 fault
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [LW-1:0]   rem;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_nxt;
    logic [LW-1:0]   win_len;
    logic [NREQ-1:0] win_oh;
    logic            reject;
    int unsigned     cand;

    // Winner: first pending request at or above the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req[PW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
        win_len = req_len[32'(win_idx)*LW +: LW];
        win_oh  = NREQ'(1) << win_idx;
        ptr_nxt = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end

`ifdef COUNTER_SCHED_GUARD_EN
    localparam int unsigned SW = ((CW > LW) ? CW : LW) + 1;
    logic [SW-1:0] head_sum;

    // Headroom check done one bit wider than the counter so the sum cannot wrap.
    always_comb begin
        head_sum = SW'(cnt_in) + SW'(win_len);
        if (req_up[win_idx]) begin
            reject = head_sum > SW'({CW{1'b1}});
        end else begin
            reject = SW'(win_len) > SW'(cnt_in);
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_in;
    assign reject     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            ptr   <= '0;
            rem   <= '0;
            act   <= 1'b0;
            up_dn <= 1'b0;
            gnt   <= '0;
            done  <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            if (ovflw_in && (state == S_RUN || state == S_WAIT || state == S_DONE)) begin
                // Overflow aborts the burst with no completion; only reset leaves FAULT.
                state <= S_FAULT;
                act   <= 1'b0;
                up_dn <= 1'b0;
                gnt   <= '0;
                busy  <= 1'b0;
                fault <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (win_found) begin
                            gnt  <= win_oh;
                            ptr  <= ptr_nxt;
                            rem  <= win_len;
                            busy <= 1'b1;
                            if (reject || win_len == '0) begin
                                state <= S_DONE;
                                done  <= win_oh;
                                err   <= reject;
                            end else begin
                                state <= S_RUN;
                                act   <= 1'b1;
                                up_dn <= req_up[win_idx];
                            end
                        end
                    end
                    S_RUN: begin
                        if (rem == LW'(1)) begin
                            state <= S_WAIT;
                            act   <= 1'b0;
                            up_dn <= 1'b0;
                        end else begin
                            rem <= rem - 1'b1;
                        end
                    end
                    S_WAIT: begin
                        state <= S_DONE;
                        done  <= gnt;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                    S_FAULT: begin
                        state <= S_FAULT;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed self-checking bench for counter_sched with a behavioural shared counter.
// Expectations follow COUNTER_SCHED_GUARD_EN in the overflow scenario.
module tb_counter_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned LW   = 4;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_up;
    logic [NREQ*LW-1:0]  req_len;
    logic [CW-1:0]       cnt;
    logic                ovf;
    logic                act;
    logic                up_dn;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                err;
    logic                busy;
    logic                fault;

    int total = 0;
    int bad   = 0;
    logic seen_done;

    counter_sched #(.NREQ(NREQ), .CW(CW), .LW(LW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_up   (req_up),
        .req_len  (req_len),
        .cnt_in   (cnt),
        .ovflw_in (ovf),
        .act      (act),
        .up_dn    (up_dn),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .fault    (fault)
    );

    // Shared counter: one step per cycle with act high; ovflw sticks until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (act) begin
            if (up_dn) begin
                if (cnt == '1) ovf <= 1'b1;
                cnt <= cnt + 1'b1;
            end else begin
                if (cnt == '0) ovf <= 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] idx, input logic up, input logic [LW-1:0] len);
        req[idx]                 = 1'b1;
        req_up[idx]              = up;
        req_len[idx*LW +: LW]    = len;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        req     = '0;
        req_up  = '0;
        req_len = '0;
        reset_n = 1'b0;
        #1;
        chk("reset_outputs", {act, up_dn, gnt, done, err, busy, fault}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single up burst of 5 from count 0
        set_req(2'd0, 1'b1, 4'd5);
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 1);
        for (int k = 1; k <= 5; k++) begin
            chk("t1_act_up", {act, up_dn}, 2'b11);
            tick();
        end
        chk("t1_wait_act", 32'(act), 0);
        tick();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_gnt_held", 32'(gnt), 32'h1);
        chk("t1_count", 32'(cnt), 5);
        req = '0;
        tick();
        chk("t1_idle", {busy, gnt, done}, 0);

        // Burst of 15 up from count 5 (pointer now at 1)
        set_req(2'd1, 1'b1, 4'd15);
        tick();
`ifdef COUNTER_SCHED_GUARD_EN
        chk("g_done", 32'(done), 32'h2);
        chk("g_err", 32'(err), 1);
        chk("g_gnt", 32'(gnt), 32'h2);
        chk("g_act", 32'(act), 0);
        req = '0;
        tick();
        chk("g_count", 32'(cnt), 5);
        chk("g_fault", 32'(fault), 0);
        chk("g_idle", {busy, gnt, act, err}, 0);
`else
        chk("f_gnt", 32'(gnt), 32'h2);
        chk("f_act", 32'(act), 1);
        seen_done = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            tick();
            seen_done = seen_done | (|done);
        end
        chk("f_nofault_yet", 32'(fault), 0);
        tick();
        seen_done = seen_done | (|done);
        chk("f_fault", 32'(fault), 1);
        chk("f_outputs_off", {gnt, act, busy, done}, 0);
        chk("f_no_done", 32'(seen_done), 0);
        req = '0;
        set_req(2'd0, 1'b1, 4'd1);
        tick();
        tick();
        tick();
        chk("f_ignored", {gnt, act, busy, done}, 0);
        chk("f_sticky", 32'(fault), 1);
`endif

        // Reset in the middle of a len-10 burst
        do_reset();
        chk("r_fault_clear", 32'(fault), 0);
        set_req(2'd0, 1'b1, 4'd10);
        tick();
        tick();
        tick();
        chk("r_running", 32'(act), 1);
        reset_n = 1'b0;
        req     = '0;
        #1;
        chk("r_async_zero", {act, up_dn, gnt, done, err, busy, fault}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        set_req(2'd2, 1'b1, 4'd3);
        tick();
        chk("r_gnt2", 32'(gnt), 32'h4);
        chk("r_act", 32'(act), 1);
        tick();
        tick();
        tick();
        chk("r_wait", 32'(act), 0);
        tick();
        chk("r_done2", 32'(done), 32'h4);
        chk("r_count", 32'(cnt), 3);
        req = '0;
        tick();

        // Round-robin order 0, 2, 0 then a zero-length down burst on 3
        do_reset();
        set_req(2'd0, 1'b1, 4'd2);
        set_req(2'd2, 1'b1, 4'd2);
        tick();
        chk("rr_gnt0", 32'(gnt), 32'h1);
        tick();
        tick();
        tick();
        chk("rr_done0", 32'(done), 32'h1);
        req[0] = 1'b0;
        tick();
        chk("rr_gap1", {gnt, act}, 0);
        tick();
        chk("rr_gnt2", 32'(gnt), 32'h4);
        chk("rr_act2", 32'(act), 1);
        set_req(2'd0, 1'b1, 4'd2);
        set_req(2'd1, 1'b1, 4'd3);
        tick();
        tick();
        tick();
        chk("rr_done2", 32'(done), 32'h4);
        req[2] = 1'b0;
        tick();
        chk("rr_gap2", {gnt, act}, 0);
        tick();
        chk("rr_gnt0_again", 32'(gnt), 32'h1);
        tick();
        tick();
        tick();
        chk("rr_done0_again", 32'(done), 32'h1);
        chk("rr_count", 32'(cnt), 6);
        req = '0;
        set_req(2'd3, 1'b0, 4'd0);
        tick();
        chk("z_idle", {gnt, act}, 0);
        tick();
        chk("z_gnt3", 32'(gnt), 32'h8);
        chk("z_done3", 32'(done), 32'h8);
        chk("z_no_act", 32'(act), 0);
        chk("z_err", 32'(err), 0);
        req = '0;
        tick();
        chk("z_count", 32'(cnt), 6);
        chk("z_idle_after", {busy, gnt, done, act}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
